// File: rtl/copro_result_buffer_if.sv
// Result-path bundle between the ALU stage, the result buffer and the CV-X-IF result port.
// The master side drives ALU packets and core ready; the slave side is the buffer.
interface copro_result_buffer_if #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned XLEN     = 32,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic            flush_i;
    logic            alu_valid_i;
    logic [XLEN-1:0] alu_result_i;
    hartid_t         alu_hartid_i;
    id_t             alu_id_i;
    logic [4:0]      alu_rd_i;
    logic            alu_we_i;

    logic            result_valid_o;
    logic            result_ready_i;
    logic [XLEN-1:0] result_data_o;
    hartid_t         result_hartid_o;
    id_t             result_id_o;
    logic [4:0]      result_rd_o;
    logic            result_we_o;

    logic [CntW-1:0] count_o;
    logic            almost_full_o;
    logic            overflow_o;

    modport master (
        output flush_i, alu_valid_i, alu_result_i, alu_hartid_i, alu_id_i, alu_rd_i, alu_we_i,
        output result_ready_i,
        input  result_valid_o, result_data_o, result_hartid_o, result_id_o, result_rd_o,
        input  result_we_o, count_o, almost_full_o, overflow_o
    );

    modport slave (
        input  flush_i, alu_valid_i, alu_result_i, alu_hartid_i, alu_id_i, alu_rd_i, alu_we_i,
        input  result_ready_i,
        output result_valid_o, result_data_o, result_hartid_o, result_id_o, result_rd_o,
        output result_we_o, count_o, almost_full_o, overflow_o
    );
endinterface

// File: rtl/copro_result_buffer.sv
// FIFO between the unstallable coprocessor ALU and the back-pressurable CV-X-IF result port.
// Packets arriving while full (and no pop) are dropped and flagged via a sticky overflow bit.
module copro_result_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned XLEN     = 32,
    parameter type         hartid_t = logic,
    parameter type         id_t     = logic
) (
    input logic                 clk_i,
    input logic                 rst_i,
    copro_result_buffer_if.slave bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullLvl       = CntW'(DEPTH);
    localparam logic [CntW-1:0] AlmostFullLvl = CntW'(DEPTH - 1);

    logic [XLEN-1:0] data_q   [DEPTH];
    hartid_t         hartid_q [DEPTH];
    id_t             id_q     [DEPTH];
    logic [4:0]      rd_q     [DEPTH];
    logic            we_q     [DEPTH];

    logic [PtrW-1:0] wptr_q, rptr_q;
    logic [CntW-1:0] count_q;
    logic            overflow_q;

    logic valid, full, pop, push_ok;

    assign valid   = (count_q != '0);
    assign full    = (count_q == FullLvl);
    assign pop     = valid && bus.result_ready_i && !bus.flush_i;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign push_ok = bus.alu_valid_i && !bus.flush_i && (!full || pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else if (bus.flush_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + 1'b1;
            if (pop)     rptr_q <= rptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (bus.alu_valid_i && !push_ok) overflow_q <= 1'b1;
        end
    end

    // Storage needs no reset: outputs are masked whenever the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            data_q[wptr_q]   <= bus.alu_result_i;
            hartid_q[wptr_q] <= bus.alu_hartid_i;
            id_q[wptr_q]     <= bus.alu_id_i;
            rd_q[wptr_q]     <= bus.alu_rd_i;
            we_q[wptr_q]     <= bus.alu_we_i;
        end
    end

    always_comb begin
        bus.result_valid_o  = valid;
        bus.result_data_o   = '0;
        bus.result_hartid_o = '0;
        bus.result_id_o     = '0;
        bus.result_rd_o     = '0;
        bus.result_we_o     = 1'b0;
        if (valid) begin
            bus.result_data_o   = data_q[rptr_q];
            bus.result_hartid_o = hartid_q[rptr_q];
            bus.result_id_o     = id_q[rptr_q];
            bus.result_rd_o     = rd_q[rptr_q];
            bus.result_we_o     = we_q[rptr_q];
        end
        bus.count_o       = count_q;
        bus.almost_full_o = (count_q >= AlmostFullLvl);
        bus.overflow_o    = overflow_q;
    end
endmodule

// File: tb/tb_copro_result_buffer.sv
// Scoreboarded bench for copro_result_buffer: a queue model of buffer contents is updated per
// clock edge by the stimulus, and a negedge monitor checks head packet and status against it.
module tb_copro_result_buffer;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned XLEN  = 32;

    typedef struct {
        logic [31:0] data;
        logic        hart;
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
    } pkt_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;

    copro_result_buffer_if #(
        .DEPTH   (DEPTH),
        .XLEN    (XLEN),
        .hartid_t(logic),
        .id_t    (logic [3:0])
    ) bus ();

    copro_result_buffer #(
        .DEPTH   (DEPTH),
        .XLEN    (XLEN),
        .hartid_t(logic),
        .id_t    (logic [3:0])
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    int   total = 0;
    int   bad   = 0;
    pkt_t exp_q[$];
    int   occ = 0;
    bit   ovf = 1'b0;
    bit   chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic pkt_t rand_pkt(input logic [3:0] id);
        pkt_t p;
        p.data = $urandom;
        p.hart = 1'($urandom_range(0, 1));
        p.id   = id;
        p.rd   = 5'($urandom_range(0, 31));
        p.we   = 1'($urandom_range(0, 1));
        return p;
    endfunction

    // Drive one cycle of stimulus, then update the model at the clock edge.
    task automatic cycle(input logic v, input pkt_t p, input logic rdy, input logic fl);
        bit pop_w, acc;
        bus.alu_valid_i    = v;
        bus.alu_result_i   = p.data;
        bus.alu_hartid_i   = p.hart;
        bus.alu_id_i       = p.id;
        bus.alu_rd_i       = p.rd;
        bus.alu_we_i       = p.we;
        bus.result_ready_i = rdy;
        bus.flush_i        = fl;
        pop_w = (occ != 0) && rdy && !fl;
        acc   = v && !fl && ((occ < int'(DEPTH)) || pop_w);
        @(posedge clk_i);
        if (fl) begin
            exp_q.delete();
            occ = 0;
            ovf = 1'b0;
        end else begin
            if (acc) exp_q.push_back(p);
            occ = occ + int'(acc) - int'(pop_w);
            if (v && !acc) ovf = 1'b1;
        end
        #1;
    endtask

    task automatic idle(input logic rdy, input int n);
        pkt_t z;
        z = '{default: '0};
        for (int i = 0; i < n; i++) cycle(1'b0, z, rdy, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(bus.result_valid_o), 64'(0));
        chk({tag, "_count"}, 64'(bus.count_o), 64'(0));
        chk({tag, "_af"}, 64'(bus.almost_full_o), 64'(0));
        chk({tag, "_ovf"}, 64'(bus.overflow_o), 64'(0));
        chk({tag, "_data"}, 64'(bus.result_data_o), 64'(0));
        chk({tag, "_id"}, 64'(bus.result_id_o), 64'(0));
        chk({tag, "_rd"}, 64'(bus.result_rd_o), 64'(0));
        chk({tag, "_we"}, 64'(bus.result_we_o), 64'(0));
        chk({tag, "_hart"}, 64'(bus.result_hartid_o), 64'(0));
    endtask

    // Pulse reset between clock edges; outputs must clear without waiting for an edge.
    task automatic pulse_reset();
        chk_en = 1'b0;
        #2 rst_i = 1'b1;
        #1 check_all_zero("async_rst");
        bus.alu_valid_i    = 1'b0;
        bus.result_ready_i = 1'b0;
        bus.flush_i        = 1'b0;
        #2 rst_i = 1'b0;
        exp_q.delete();
        occ = 0;
        ovf = 1'b0;
        @(posedge clk_i);
        #1 chk_en = 1'b1;
    endtask

    always @(negedge clk_i) begin
        if (chk_en) begin
            chk("count", 64'(bus.count_o), 64'(occ));
            chk("valid", 64'(bus.result_valid_o), 64'(occ != 0));
            chk("almost_full", 64'(bus.almost_full_o), 64'(occ >= int'(DEPTH) - 1));
            chk("overflow", 64'(bus.overflow_o), 64'(ovf));
            if (bus.result_valid_o) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_valid: got id %0h want no packet", bus.result_id_o);
                end else begin
                    chk("data", 64'(bus.result_data_o), 64'(exp_q[0].data));
                    chk("id", 64'(bus.result_id_o), 64'(exp_q[0].id));
                    chk("rd", 64'(bus.result_rd_o), 64'(exp_q[0].rd));
                    chk("we", 64'(bus.result_we_o), 64'(exp_q[0].we));
                    chk("hart", 64'(bus.result_hartid_o), 64'(exp_q[0].hart));
                    if (bus.result_ready_i) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        pkt_t p;
        bus.flush_i        = 1'b0;
        bus.alu_valid_i    = 1'b0;
        bus.alu_result_i   = '0;
        bus.alu_hartid_i   = 1'b0;
        bus.alu_id_i       = '0;
        bus.alu_rd_i       = '0;
        bus.alu_we_i       = 1'b0;
        bus.result_ready_i = 1'b0;

        repeat (2) @(posedge clk_i);
        #1 check_all_zero("reset");
        rst_i = 1'b0;
        chk_en = 1'b1;
        idle(1'b1, 2);

        // Single packet, ready high: visible the cycle after the push edge.
        p = '{data: 32'h5, hart: 1'b0, id: 4'd1, rd: 5'd3, we: 1'b1};
        cycle(1'b1, p, 1'b1, 1'b0);
        idle(1'b1, 3);

        // Fill with ready low, then overflow on the 5th push, then drain.
        for (int i = 0; i < 4; i++) cycle(1'b1, rand_pkt(4'(i)), 1'b0, 1'b0);
        cycle(1'b1, rand_pkt(4'd4), 1'b0, 1'b0);
        idle(1'b0, 1);
        idle(1'b1, 5);

        // Clear overflow, refill, then push and pop together while full.
        idle(1'b0, 0);
        p = '{default: '0};
        cycle(1'b0, p, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b1, rand_pkt(4'(8 + i)), 1'b0, 1'b0);
        cycle(1'b1, rand_pkt(4'd7), 1'b1, 1'b0);
        idle(1'b1, 6);

        // Continuous stream with ready toggling; pointers wrap several times.
        for (int i = 0; i < 10; i++) cycle(1'b1, rand_pkt(4'(i)), 1'(~i & 1), 1'b0);
        idle(1'b1, 8);

        // Three buffered, then flush with a simultaneous push.
        for (int i = 0; i < 3; i++) cycle(1'b1, rand_pkt(4'(i)), 1'b0, 1'b0);
        cycle(1'b1, rand_pkt(4'd9), 1'b1, 1'b1);
        idle(1'b1, 2);

        // Mid-operation reset with data buffered and overflow set.
        for (int i = 0; i < 6; i++) cycle(1'b1, rand_pkt(4'(i)), 1'b0, 1'b0);
        pulse_reset();
        idle(1'b1, 2);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), rand_pkt(4'($urandom_range(0, 15))),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
        end

        // Bounded drain; any leftover expected packet counts as a failure.
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1, 1);
        idle(1'b1, 1);
        chk("drain_left", 64'(exp_q.size()), 64'(0));

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/copro_result_buffer.md
Name: copro_result_buffer

Overview:
- Result buffer directly downstream of the coprocessor ALU stage in the CV-X-IF example coprocessor.
- Captures every valid ALU result packet (result, hartid, id, rd, we) into a FIFO.
- Presents packets to the CV-X-IF result interface with a valid/ready handshake.
- Exists because the ALU produces one packet per cycle and cannot be stalled, while the core may back-pressure the result interface.

Parameters:
- DEPTH, 4, number of buffered packets; power of two, at least 2.
- XLEN, 32, result data width.
- hartid_t, logic, hart identifier type.
- id_t, logic, instruction identifier type.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- flush_i  in  1  synchronous clear of all buffered entries
- alu_valid_i  in  1  ALU packet valid this cycle
- alu_result_i  in  XLEN  ALU result data
- alu_hartid_i  in  hartid_t  packet hart id
- alu_id_i  in  id_t  packet instruction id
- alu_rd_i  in  5  destination register
- alu_we_i  in  1  register write enable
- result_valid_o  out  1  head packet valid
- result_ready_i  in  1  core accepts head packet
- result_data_o  out  XLEN  head result
- result_hartid_o  out  hartid_t  head hart id
- result_id_o  out  id_t  head id
- result_rd_o  out  5  head rd
- result_we_o  out  1  head we
- count_o  out  $clog2(DEPTH+1)  occupancy
- almost_full_o  out  1  count_o >= DEPTH-1; issue logic stops accepting offloads
- overflow_o  out  1  sticky: a packet was dropped

Behaviour:
- Reset: rst_i asynchronous; the async reset applies when rst_i=1.
  - While reset: pointers=0, count_o=0, result_valid_o=0, overflow_o=0, almost_full_o=0, all result_*_o=0.
  - Reset mid-operation discards all entries immediately.
- Storage: circular buffer of DEPTH entries; write and read pointers of $clog2(DEPTH) bits wrap modulo DEPTH; separate occupancy counter 0..DEPTH.
- Pop (pop = result_valid_o & result_ready_i):
  - Head advances at the clock edge.
  - result_valid_o = (count_o != 0).
  - Outputs come from the head entry (read-mux, registered storage).
  - Outputs stay stable while valid and not ready.
- Push: at a clock edge with alu_valid_i=1.
  - Latency: a packet pushed into an empty buffer appears on result_*_o with result_valid_o=1 in the cycle after the push edge.
  - No combinational bypass from alu_* to result_*.
- Simultaneous push and pop:
  - When full: the push is accepted (the slot frees); count unchanged.
  - When empty: impossible, because pop requires valid.
  - Otherwise: count unchanged, both pointers advance.
- Full with push and no pop:
  - Packet dropped; state unchanged.
  - overflow_o set to 1 and held until rst_i or flush_i.
- flush_i (synchronous, highest priority after reset):
  - Pointers=0, count=0, overflow_o=0.
  - A same-cycle push or pop is ignored.
- almost_full_o: combinational from count_o; 1 when count_o >= DEPTH-1.
- Packets with alu_we_i=0 (NOP) are buffered and delivered like any other packet; no filtering.
- Order: strict FIFO; no reordering across harts.

Test Plan:
- Reset then idle, rst_i pulsed mid-cycle -> all outputs 0 asynchronously; count_o=0 and result_valid_o=0 after release.
- Push {result=0x0000_0005, id=1, rd=3, we=1}, ready=1 -> result_valid_o=1 exactly one cycle later with data 0x5, rd=3; count_o returns 0 after the handshake.
- ready=0, push 4 packets id=0..3 -> count_o=4, almost_full_o=1 from count 3.
  - A 5th push (id=4) -> dropped, overflow_o=1.
  - Then ready=1 for 4 cycles -> ids 0,1,2,3 delivered in order, never id=4.
- Full buffer with push id=7 and pop in the same cycle -> count stays 4; id=7 is delivered last; overflow_o stays 0.
- Continuous push/pop for 10 packets with ready toggling 1,0,1,0 -> no loss, order preserved, outputs stable while ready=0, pointers wrap correctly past DEPTH.
- Three packets buffered, flush_i=1 with a simultaneous push -> next cycle count_o=0, result_valid_o=0, overflow_o=0; the pushed packet is not stored.
